pipe_buf: RTL and testbench

PIPE_BUF -- requirements
Module: pipe_buf

---
 rtl/pipe_buf_pkg.sv | 20 ++
 rtl/pipe_buf_if.sv | 29 ++
 rtl/pipe_buf_entry.sv | 44 ++++
 rtl/pipe_buf.sv | 169 ++++++++++++++++
 tb/tb_pipe_buf.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/pipe_buf_pkg.sv
// Shared types for the pipe_buf pipeline buffer: storage state encoding,
// occupancy count type and the default reset payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HEAD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef logic [1:0] count_t;

  localparam logic [63:0] DEF_RST_VAL = 64'd0;

  // The state encoding doubles as the number of held beats.
  function automatic count_t stateCount(input state_t s);
    return count_t'(s);
  endfunction

endpackage

// File: rtl/pipe_buf_if.sv
// Handshake bundle between upstream producer, pipe_buf and downstream consumer.
// The buffer connects through the slave modport; the driving side uses master.
interface pipe_buf_if #(
  parameter int DATA_W = 64
);
  import pipe_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_int;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_int;
  count_t            o_count;

  modport master (
    output i_valid, i_data, i_int, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_int, o_count
  );

  modport slave (
    input  i_valid, i_data, i_int, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_int, o_count
  );

endinterface

// File: rtl/pipe_buf_entry.sv
// One storage slot of pipe_buf: valid flag, payload and interrupt tag.
// Clear wins over load and returns the slot to the reset payload.
module pipe_buf_entry #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              int_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              int_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              int_q;

  // An empty slot always holds RST_VAL and a cleared tag, so the owner can
  // drive its outputs straight from the registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
      int_q   <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
      int_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      int_q   <= int_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign int_o   = int_q;

endmodule

// File: rtl/pipe_buf.sv
// Pipeline buffer carrying {data, int} beats with valid/ready handshakes.
// Define PIPE_BUF_SKID_EN for a registered-ready two-entry skid buffer.
module pipe_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(DEF_RST_VAL)
) (
  input logic       clk,
  input logic       rst,
  pipe_buf_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              deq;
  logic              headLoad;
  logic              headClear;
  logic              headValid;
  logic [DATA_W-1:0] headData;
  logic              headInt;
  logic [DATA_W-1:0] headDataIn;
  logic              headIntIn;

  assign accept = bus.i_valid && bus.o_ready;
  assign deq    = headValid && bus.i_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_BUF_SKID_EN
  logic              skidLoad;
  logic              skidClear;
  logic              headFromSkid;
  logic              skidValid;
  logic [DATA_W-1:0] skidData;
  logic              skidInt;

  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = HEAD;
        HEAD: begin
          if (deq && !accept) state_d = EMPTY;
          else if (accept && !deq) state_d = FULL;
        end
        FULL:    if (deq) state_d = HEAD;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Skid is only ever filled behind a stalled head; it drains into the head
  // on the same edge the head leaves, so arrival order is kept.
  always_comb begin
    headLoad     = 1'b0;
    headClear    = 1'b0;
    headFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (bus.i_flush) begin
      headClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: headLoad = accept;
        HEAD: begin
          if (accept && deq) headLoad = 1'b1;
          else if (accept) skidLoad = 1'b1;
          else if (deq) headClear = 1'b1;
        end
        FULL: begin
          if (deq) begin
            headLoad     = 1'b1;
            headFromSkid = 1'b1;
            skidClear    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign headDataIn = headFromSkid ? skidData : bus.i_data;
  assign headIntIn  = headFromSkid ? skidInt  : bus.i_int;

  pipe_buf_entry #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skidLoad),
    .clear_i (skidClear),
    .data_i  (bus.i_data),
    .int_i   (bus.i_int),
    .valid_o (skidValid),
    .data_o  (skidData),
    .int_o   (skidInt)
  );

  assign bus.o_ready = !skidValid;
`else
  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = HEAD;
        HEAD:    if (deq && !accept) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // With a single slot an accept in HEAD implies the head is leaving too.
  always_comb begin
    headLoad  = 1'b0;
    headClear = 1'b0;
    if (bus.i_flush) begin
      headClear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: headLoad = accept;
        HEAD: begin
          if (accept) headLoad = 1'b1;
          else if (deq) headClear = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign headDataIn  = bus.i_data;
  assign headIntIn   = bus.i_int;
  assign bus.o_ready = bus.i_ready || !headValid;
`endif

  pipe_buf_entry #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_head (
    .clk     (clk),
    .rst     (rst),
    .load_i  (headLoad),
    .clear_i (headClear),
    .data_i  (headDataIn),
    .int_i   (headIntIn),
    .valid_o (headValid),
    .data_o  (headData),
    .int_o   (headInt)
  );

  assign bus.o_valid = headValid;
  assign bus.o_data  = headData;
  assign bus.o_int   = headInt;
  assign bus.o_count = stateCount(state_q);

endmodule

// File: tb/tb_pipe_buf.sv
// Directed table-driven bench for pipe_buf; expectations follow the build
// selected by PIPE_BUF_SKID_EN.
module tb_pipe_buf;

  localparam int          DW = 16;
  localparam logic [15:0] RV = 16'hA5A5;
`ifdef PIPE_BUF_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        v;
    logic [15:0] d;
    logic        it;
    logic        fl;
    logic        rdy;
    logic        expReady;
    logic        expValid;
    logic [15:0] expData;
    logic        expInt;
    logic [1:0]  expCount;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t vecs[$];

  pipe_buf_if #(.DATA_W(DW)) bus();

  pipe_buf #(
    .DATA_W  (DW),
    .RST_VAL (RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic it,
                               input logic fl, input logic rdy);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_int   = it;
    bus.i_flush = fl;
    bus.i_ready = rdy;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [15:0] ed,
                             input logic ei, input logic [1:0] ec);
    check({name, "/valid"}, 16'(bus.o_valid), 16'(ev));
    check({name, "/data"},  bus.o_data,       ed);
    check({name, "/int"},   16'(bus.o_int),   16'(ei));
    check({name, "/count"}, 16'(bus.o_count), 16'(ec));
  endtask

  function automatic void addVec(input string n, input logic v, input logic [15:0] d,
                                 input logic it, input logic fl, input logic rdy,
                                 input logic er, input logic ev, input logic [15:0] ed,
                                 input logic ei, input logic [1:0] ec);
    vec_t t;
    t.name = n; t.v = v; t.d = d; t.it = it; t.fl = fl; t.rdy = rdy;
    t.expReady = er; t.expValid = ev; t.expData = ed; t.expInt = ei; t.expCount = ec;
    vecs.push_back(t);
  endfunction

  initial begin
    errors = 0;
    checks = 0;

    //     name        v  data      int fl rdy | ready valid data      int cnt
    addVec("single",   1, 16'h1234, 1,  0, 1,    1,    1,    16'h1234, 1,  2'd1);
    addVec("drain0",   0, 16'h0000, 0,  0, 1,    1,    0,    RV,       0,  2'd0);
    for (int k = 1; k <= 8; k++) begin
      addVec($sformatf("stream%0d", k), 1, 16'(k), 1'(k[0]), 0, 1,
             1, 1, 16'(k), 1'(k[0]), 2'd1);
    end
    addVec("drain1",   0, 16'h0000, 0,  0, 1,    1,    0,    RV,       0,  2'd0);
    addVec("load55",   1, 16'h0055, 0,  0, 1,    1,    1,    16'h0055, 0,  2'd1);
    addVec("stall1",   0, 16'h0000, 0,  0, 0,    SKID, 1,    16'h0055, 0,  2'd1);
    addVec("stall2",   0, 16'h0000, 0,  0, 0,    SKID, 1,    16'h0055, 0,  2'd1);
    addVec("release",  0, 16'h0000, 0,  0, 1,    1,    0,    RV,       0,  2'd0);
    addVec("load77",   1, 16'h0077, 1,  0, 1,    1,    1,    16'h0077, 1,  2'd1);
    addVec("flushHd",  1, 16'h0088, 0,  1, 0,    SKID, 0,    RV,       0,  2'd0);
    addVec("postFlH",  0, 16'h0000, 0,  0, 1,    1,    0,    RV,       0,  2'd0);
`ifdef PIPE_BUF_SKID_EN
    addVec("bpA",      1, 16'h0A0A, 0,  0, 0,    1,    1,    16'h0A0A, 0,  2'd1);
    addVec("bpB",      1, 16'h0B0B, 1,  0, 0,    1,    1,    16'h0A0A, 0,  2'd2);
    addVec("bpCheld",  1, 16'h0C0C, 0,  0, 0,    0,    1,    16'h0A0A, 0,  2'd2);
    addVec("bpOutA",   1, 16'h0C0C, 0,  0, 1,    0,    1,    16'h0B0B, 1,  2'd1);
    addVec("bpOutB",   1, 16'h0C0C, 0,  0, 1,    1,    1,    16'h0C0C, 0,  2'd1);
    addVec("bpOutC",   0, 16'h0000, 0,  0, 1,    1,    0,    RV,       0,  2'd0);
    addVec("fill11",   1, 16'h0011, 1,  0, 0,    1,    1,    16'h0011, 1,  2'd1);
    addVec("fill22",   1, 16'h0022, 0,  0, 0,    1,    1,    16'h0011, 1,  2'd2);
    addVec("flushFul", 1, 16'h0033, 1,  1, 0,    0,    0,    RV,       0,  2'd0);
    addVec("postFlF",  0, 16'h0000, 0,  0, 1,    1,    0,    RV,       0,  2'd0);
`endif

    rst = 1'b0;
    applyStimulus(0, 16'h0000, 0, 0, 0);
    #12;
    checkOutput("reset", 0, RV, 0, 2'd0);
    check("reset/ready", 16'(bus.o_ready), 16'd1);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].it, vecs[i].fl, vecs[i].rdy);
      #1;
      check({vecs[i].name, "/ready"}, 16'(bus.o_ready), 16'(vecs[i].expReady));
      @(posedge clk);
      #1;
      checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expData,
                  vecs[i].expInt, vecs[i].expCount);
    end

    // Asynchronous reset in the middle of a cycle with the buffer occupied.
    @(negedge clk);
    applyStimulus(1, 16'h00AA, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1, 16'h00BB, 1, 0, 0);
    @(posedge clk);
    #2;
    checkOutput("preRst", 1, 16'h00AA, 0, SKID ? 2'd2 : 2'd1);
    rst = 1'b0;
    applyStimulus(0, 16'h0000, 0, 0, 0);
    #1;
    checkOutput("asyncRst", 0, RV, 0, 2'd0);
    check("asyncRst/ready", 16'(bus.o_ready), 16'd1);
    @(posedge clk);
    #1;
    checkOutput("heldRst", 0, RV, 0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1, 16'h0099, 1, 0, 1);
    #1;
    check("postRst/ready", 16'(bus.o_ready), 16'd1);
    @(posedge clk);
    #1;
    checkOutput("postRst", 1, 16'h0099, 1, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
